reg_bank_arbiter: RTL and testbench

//  Owns a 2**AW x WIDTH register bank and shares it between two requesters.

---
 rtl/reg_bank_pkg.sv | 19 +
 rtl/reg_word.sv | 34 +++
 rtl/reg_bank_arbiter.sv | 120 ++++++++++++
 tb/tb_reg_bank_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_bank_pkg
// Purpose : Shared constants for the arbitrated register bank: FSM state
//           encoding and the default bank geometry.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

  localparam int DEF_WIDTH = 8;  // data bits per bank word
  localparam int DEF_AW    = 3;  // address bits; depth = 2**AW

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/reg_word.sv
`default_nettype none
// ============================================================================
// Module  : reg_word
// Purpose : One storage word of the register bank: WIDTH-bit register with a
//           synchronous load enable and an asynchronous active-low clear.
// Ports   : clk     - rising-edge clock
//           clear_n - asynchronous active-low clear (word -> 0)
//           load    - load d into the word at the next rising edge
//           d       - write data
//           q       - stored word
// Revision: 1.0 - initial release
// ============================================================================
module reg_word
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : reg_bank_arbiter
// Purpose : Owns a 2**AW x WIDTH register bank and serialises single read or
//           write transactions from two requesters with a round-robin
//           arbiter. One transaction occupies IDLE -> ACCESS -> DONE.
// Ports   : clk                 - rising-edge clock
//           reset               - asynchronous active-low reset (clears bank)
//           req0/we0/addr0/wdata0 - requester 0 request and its fields
//           gnt0/done0          - requester 0 accept / complete pulses
//           req1/we1/addr1/wdata1 - requester 1 request and its fields
//           gnt1/done1          - requester 1 accept / complete pulses
//           rdata               - read result, valid with done0/done1
// Revision: 1.0 - initial release
// ============================================================================
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             done0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             done1,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [1:0]       state;
  logic             owner;      // requester currently being served
  logic             last;       // requester served most recently
  logic             lat_we;
  logic [AW-1:0]    lat_addr;
  logic [WIDTH-1:0] lat_wdata;

  logic [WIDTH-1:0] word_q [DEPTH];
  logic             write_en;
  logic             pick1;

  // Requester 1 wins when alone, or on a tie when requester 0 went last.
  assign pick1    = req1 && (!req0 || !last);
  assign write_en = (state == ST_ACCESS) && lat_we;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk     (clk),
      .clear_n (reset),
      .load    (write_en && (lat_addr == AW'(i))),
      .d       (lat_wdata),
      .q       (word_q[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;   // makes requester 0 win the first tie
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
    end else begin
      // gnt/done are single-cycle pulses
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            owner     <= pick1;
            lat_we    <= pick1 ? we1    : we0;
            lat_addr  <= pick1 ? addr1  : addr0;
            lat_wdata <= pick1 ? wdata1 : wdata0;
            gnt0      <= !pick1;
            gnt1      <= pick1;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // The bank word itself loads via write_en; reads update rdata.
          if (!lat_we) begin
            rdata <= word_q[lat_addr];
          end
          last  <= owner;
          done0 <= !owner;
          done1 <= owner;
          state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_bank_arbiter
// Purpose : Self-checking bench for reg_bank_arbiter against a transaction-
//           level model (bank array, last-served requester, last read value).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_bank_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, we0, gnt0, done0;
  logic       req1, we1, gnt1, done1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1, rdata;

  int errors;
  int checks;

  // Transaction-level reference model
  logic [7:0] m_bank [8];
  logic       m_last;
  logic [7:0] m_rdata;

  reg_bank_arbiter #(
    .WIDTH (8),
    .AW    (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .we0    (we0),
    .addr0  (addr0),
    .wdata0 (wdata0),
    .gnt0   (gnt0),
    .done0  (done0),
    .req1   (req1),
    .we1    (we1),
    .addr1  (addr1),
    .wdata1 (wdata1),
    .gnt1   (gnt1),
    .done1  (done1),
    .rdata  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_bank[i] = 8'h00;
    m_last  = 1'b1;
    m_rdata = 8'h00;
  endtask

  task automatic set_req(input int r, input logic rq, input logic we,
                         input logic [2:0] a, input logic [7:0] d);
    if (r == 0) begin
      req0 = rq; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = rq; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic model_apply(input int r, input logic we,
                             input logic [2:0] a, input logic [7:0] d);
    if (we) m_bank[a] = d;
    else    m_rdata   = m_bank[a];
    m_last = (r != 0);
  endtask

  // Called #1 after a posedge with the DUT in IDLE; returns the same way.
  task automatic txn(input int r, input logic we, input logic [2:0] a,
                     input logic [7:0] d, input string tag);
    logic [1:0] exp;
    exp = (r != 0) ? 2'b10 : 2'b01;
    set_req(r, 1'b1, we, a, d);
    @(posedge clk); #1;
    checks++;
    if ({gnt1, gnt0} !== exp || {done1, done0} !== 2'b00) begin
      errors++;
      $display("FAIL %s_gnt: got gnt1,gnt0=%b done1,done0=%b want gnt=%b done=00",
               tag, {gnt1, gnt0}, {done1, done0}, exp);
    end
    set_req(r, 1'b0, 1'b0, 3'd0, 8'h00);
    model_apply(r, we, a, d);
    @(posedge clk); #1;
    checks++;
    if ({done1, done0} !== exp || {gnt1, gnt0} !== 2'b00 || rdata !== m_rdata) begin
      errors++;
      $display("FAIL %s_done: got done=%b gnt=%b rdata=%h want done=%b gnt=00 rdata=%h",
               tag, {done1, done0}, {gnt1, gnt0}, rdata, exp, m_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({gnt1, gnt0, done1, done0} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_idle: got gnt=%b done=%b want all 0",
               tag, {gnt1, gnt0}, {done1, done0});
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 3'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_clear();
    for (int c = 0; c < 6; c++) begin
      req0 = 1'($urandom); we0 = 1'($urandom); addr0 = 3'($urandom); wdata0 = 8'($urandom);
      req1 = 1'($urandom); we1 = 1'($urandom); addr1 = 3'($urandom); wdata1 = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({gnt1, gnt0, done1, done0} !== 4'b0000 || rdata !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs: got gnt=%b done=%b rdata=%h want 0",
                 {gnt1, gnt0}, {done1, done0}, rdata);
      end
    end
    set_req(0, 1'b0, 1'b0, 3'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) begin
      txn(int'($urandom_range(0, 1)), 1'b0, 3'(a), 8'h00, "reset_read");
    end
  endtask

  task automatic test_write_read();
    txn(0, 1'b1, 3'd3, 8'hA5, "wr0_a3");
    txn(0, 1'b0, 3'd3, 8'h00, "rd0_a3");
    checks++;
    if (rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rd_a3_value: got rdata=%h want a5", rdata);
    end
  endtask

  // Both requesters hold req high; grants must alternate 0,1,0,1.
  task automatic test_tie_alternation();
    logic [2:0] a [2];
    logic [7:0] d [2];
    int         w;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      a[r] = 3'($urandom); d[r] = 8'($urandom);
      set_req(r, 1'b1, 1'b1, a[r], d[r]);
    end
    for (int t = 0; t < 4; t++) begin
      w = (t % 2 == 0) ? 0 : 1;
      checks++;
      if (w != (m_last ? 0 : 1)) begin
        errors++;
        $display("FAIL tie_model_order: got winner=%0d want %0d", m_last ? 0 : 1, w);
      end
      @(posedge clk); #1;
      checks++;
      if ({gnt1, gnt0} !== (w != 0 ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL tie_gnt%0d: got gnt1,gnt0=%b want winner %0d", t, {gnt1, gnt0}, w);
      end
      model_apply(w, 1'b1, a[w], d[w]);
      a[w] = 3'($urandom); d[w] = 8'($urandom);
      set_req(w, 1'b1, 1'b1, a[w], d[w]);
      @(posedge clk); #1;
      checks++;
      if ({done1, done0} !== (w != 0 ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL tie_done%0d: got done1,done0=%b want winner %0d", t, {done1, done0}, w);
      end
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, 3'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Confirm the written words through reads
    for (int i = 0; i < 8; i++) txn(1, 1'b0, 3'(i), 8'h00, "tie_readback");
  endtask

  // Requester 1 alone, req1 held for 4 reads: done1 on every third cycle.
  task automatic test_back_to_back();
    logic [2:0] ra;
    logic [7:0] exp_rd;
    ra = 3'($urandom);
    set_req(1, 1'b1, 1'b0, ra, 8'h00);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c % 3 == 0) begin
        exp_rd = m_bank[ra];
        ra = 3'($urandom);
        if (c == 9) set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
        else        set_req(1, 1'b1, 1'b0, ra, 8'h00);
      end
      if (c % 3 == 1) m_rdata = exp_rd;
      checks++;
      if (gnt1 !== (c % 3 == 0) || done1 !== (c % 3 == 1) || gnt0 !== 1'b0 ||
          done0 !== 1'b0 || (c % 3 == 1 && rdata !== m_rdata)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got gnt=%b done=%b rdata=%h want gnt1=%0d done1=%0d rdata=%h",
                 c, {gnt1, gnt0}, {done1, done0}, rdata, c % 3 == 0, c % 3 == 1, m_rdata);
      end
    end
    m_last = 1'b1;
  endtask

  task automatic test_ff_hold();
    txn(0, 1'b1, 3'd7, 8'hFF, "wr_a7_ff");
    txn(1, 1'b0, 3'd7, 8'h00, "rd1_a7");
    checks++;
    if (rdata !== 8'hFF) begin
      errors++;
      $display("FAIL rd_a7_value: got rdata=%h want ff", rdata);
    end
    txn(1, 1'b1, 3'd4, 8'h3C, "wr_hold_rdata");
    checks++;
    if (rdata !== 8'hFF) begin
      errors++;
      $display("FAIL rdata_hold: got rdata=%h want ff", rdata);
    end
  endtask

  task automatic test_random_arbitration();
    logic       rq [2];
    logic       we [2];
    logic [2:0] a  [2];
    logic [7:0] d  [2];
    int         w;
    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < 2; r++) begin
        rq[r] = 1'($urandom); we[r] = 1'($urandom);
        a[r] = 3'($urandom); d[r] = 8'($urandom);
        set_req(r, rq[r], we[r], a[r], d[r]);
      end
      @(posedge clk); #1;
      if (!rq[0] && !rq[1]) begin
        checks++;
        if ({gnt1, gnt0, done1, done0} !== 4'b0000) begin
          errors++;
          $display("FAIL rand_nogrant%0d: got gnt=%b done=%b want 0", t, {gnt1, gnt0}, {done1, done0});
        end
      end else begin
        if (rq[0] && rq[1]) w = m_last ? 0 : 1;
        else                w = rq[1] ? 1 : 0;
        checks++;
        if ({gnt1, gnt0} !== (w != 0 ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rand_gnt%0d: got gnt1,gnt0=%b want winner %0d", t, {gnt1, gnt0}, w);
        end
        set_req(0, 1'b0, 1'b0, 3'd0, 8'h00);
        set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
        model_apply(w, we[w], a[w], d[w]);
        @(posedge clk); #1;
        checks++;
        if ({done1, done0} !== (w != 0 ? 2'b10 : 2'b01) || rdata !== m_rdata) begin
          errors++;
          $display("FAIL rand_done%0d: got done=%b rdata=%h want winner %0d rdata=%h",
                   t, {done1, done0}, rdata, w, m_rdata);
        end
        @(posedge clk); #1;
      end
    end
    set_req(0, 1'b0, 1'b0, 3'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic test_reset_mid_op();
    txn(0, 1'b1, 3'd2, 8'h5A, "mid_wr_a2");
    txn(0, 1'b0, 3'd2, 8'h00, "mid_rd_a2");
    set_req(0, 1'b1, 1'b1, 3'd2, 8'hC3);
    @(posedge clk); #1;
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt: got gnt0=%b want 1", gnt0);
    end
    set_req(0, 1'b0, 1'b0, 3'd0, 8'h00);
    #2 reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (gnt0 !== 1'b0 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL mid_async_clear: got gnt0=%b rdata=%h want 0 00", gnt0, rdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({done1, done0} !== 2'b00) begin
      errors++;
      $display("FAIL mid_no_done: got done=%b want 00", {done1, done0});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({gnt1, gnt0, done1, done0} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_after_release: got gnt=%b done=%b want 0", {gnt1, gnt0}, {done1, done0});
    end
    txn(1, 1'b0, 3'd2, 8'h00, "mid_rd_cleared");
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL mid_bank2: got rdata=%h want 00", rdata);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    set_req(0, 1'b0, 1'b0, 3'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
    test_reset();
    test_write_read();
    test_tie_alternation();
    test_back_to_back();
    test_ff_hold();
    test_random_arbitration();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
